// File: rtl/otter_pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage OTTER pipeline: stage valids, stalls, flushes, forward selects.
// Build option: define OTTER_FWD_EN for EX forwarding with a single-cycle load-use stall; otherwise DE interlocks on any in-flight writer.
module otter_pipe_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       de_rs1,
  input  logic [4:0]       de_rs2,
  input  logic             de_rs1_used,
  input  logic             de_rs2_used,
  input  logic [4:0]       ex_rd,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic [4:0]       mem_rd,
  input  logic             mem_reg_write,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  output logic             stall_pc,
  output logic             stall_if,
  output logic             stall_de,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             ifde_valid,
  output logic             deex_valid,
  output logic             exmem_valid,
  output logic             memwb_valid,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

  state_t state, stateNext;

  // A producer hits a DE source only if that source is read and the dest is not x0.
  function automatic logic srcHit(input logic [4:0] rd, input logic [4:0] src, input logic used);
    return used && (rd != 5'd0) && (rd == src);
  endfunction

  logic exMatch, memMatch, wbMatch;
  logic memWait, flush, deHaz;

  assign exMatch  = srcHit(ex_rd, de_rs1, de_rs1_used) | srcHit(ex_rd, de_rs2, de_rs2_used);
  assign memMatch = srcHit(mem_rd, de_rs1, de_rs1_used) | srcHit(mem_rd, de_rs2, de_rs2_used);
  assign wbMatch  = srcHit(wb_rd, de_rs1, de_rs1_used) | srcHit(wb_rd, de_rs2, de_rs2_used);

  assign memWait = mem_access & exmem_valid & ~dmem_ready;
  assign flush   = deex_valid & ex_branch_taken & ~memWait;

`ifdef OTTER_FWD_EN
  logic [1:0] fwdA, fwdB;
  logic unusedWb;

  // Youngest producer wins: the EX result is newer than the one in MEM.
  function automatic logic [1:0] fwdSel(
    input logic [4:0] src, input logic used,
    input logic [4:0] exRd, input logic exHot,
    input logic [4:0] memRd, input logic memHot
  );
    if (!used || src == 5'd0) return 2'b00;
    if (exHot && exRd == src)   return 2'b01;
    if (memHot && memRd == src) return 2'b10;
    return 2'b00;
  endfunction

  // LU_STALL guarantees the load-use stall lasts exactly one cycle.
  assign deHaz     = ifde_valid & deex_valid & ex_mem_read & ex_reg_write & exMatch & (state != LU_STALL);
  assign fwd_a_sel = fwdA;
  assign fwd_b_sel = fwdB;
  assign unusedWb  = ^{wb_rd, wb_reg_write, memMatch, wbMatch};
`else
  logic unusedLoad;

  assign deHaz = ifde_valid & ((deex_valid & ex_reg_write & exMatch) |
                               (exmem_valid & mem_reg_write & memMatch) |
                               (memwb_valid & wb_reg_write & wbMatch));
  assign fwd_a_sel  = 2'b00;
  assign fwd_b_sel  = 2'b00;
  assign unusedLoad = ex_mem_read;
`endif

  always_comb begin
    // NOTE: every output gets a default first so no path through this block can infer a latch.
    stall_pc  = 1'b0;
    stall_if  = 1'b0;
    stall_de  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    stateNext = RUN;
    if (RESET) begin
      stateNext = RUN;
    end else if (memWait) begin
      {stall_pc, stall_if, stall_de, stall_ex, stall_mem} = 5'b11111;
      stateNext = MEM_WAIT;
    end else if (flush) begin
      stateNext = RUN;
    end else if (deHaz) begin
      {stall_pc, stall_if, stall_de} = 3'b111;
`ifdef OTTER_FWD_EN
      stateNext = LU_STALL;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (RESET) begin
      state       <= RUN;
      ifde_valid  <= 1'b0;
      deex_valid  <= 1'b0;
      exmem_valid <= 1'b0;
      memwb_valid <= 1'b0;
      stall_cnt   <= '0;
      flush_cnt   <= '0;
    end else begin
      state       <= stateNext;
      ifde_valid  <= stall_if ? ifde_valid : ~flush;
      deex_valid  <= stall_ex ? deex_valid : (ifde_valid & ~flush & ~deHaz);
      exmem_valid <= stall_mem ? exmem_valid : deex_valid;
      memwb_valid <= memWait ? 1'b0 : exmem_valid;
      stall_cnt   <= stall_cnt + CNT_W'(stall_pc);
      flush_cnt   <= flush_cnt + CNT_W'(flush);
    end
  end

`ifdef OTTER_FWD_EN
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fwdA <= 2'b00;
      fwdB <= 2'b00;
    end else if (!stall_de) begin
      fwdA <= fwdSel(de_rs1, de_rs1_used, ex_rd, deex_valid & ex_reg_write, mem_rd, exmem_valid & mem_reg_write);
      fwdB <= fwdSel(de_rs2, de_rs2_used, ex_rd, deex_valid & ex_reg_write, mem_rd, exmem_valid & mem_reg_write);
    end
  end
`endif

endmodule

// File: tb/tb_otter_pipe_ctrl.sv
// Scoreboard bench for otter_pipe_ctrl: directed per-cycle stimulus pushes expectations, a negedge monitor compares.
module tb_otter_pipe_ctrl;

  logic        CLK, RESET;
  logic [4:0]  de_rs1, de_rs2, ex_rd, mem_rd, wb_rd;
  logic        de_rs1_used, de_rs2_used, ex_reg_write, ex_mem_read, ex_branch_taken;
  logic        mem_reg_write, mem_access, dmem_ready, wb_reg_write;
  logic        stall_pc, stall_if, stall_de, stall_ex, stall_mem;
  logic        ifde_valid, deex_valid, exmem_valid, memwb_valid;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic [31:0] stall_cnt, flush_cnt;

`ifdef OTTER_FWD_EN
  localparam int         BASE  = 1;
  localparam logic [1:0] BR_FA = 2'b01;
`else
  localparam int         BASE  = 3;
  localparam logic [1:0] BR_FA = 2'b00;
`endif

  otter_pipe_ctrl #(.CNT_W(32)) dut (
    .CLK(CLK), .RESET(RESET),
    .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rs1_used(de_rs1_used), .de_rs2_used(de_rs2_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_access(mem_access), .dmem_ready(dmem_ready),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .stall_pc(stall_pc), .stall_if(stall_if), .stall_de(stall_de), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .ifde_valid(ifde_valid), .deex_valid(deex_valid), .exmem_valid(exmem_valid), .memwb_valid(memwb_valid),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  typedef struct {
    int          cyc;
    string       name;
    logic [12:0] obs;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  logic [12:0] act;
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Monitor: compare every expectation stamped for the current cycle.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = {stall_pc, stall_if, stall_de, stall_ex, stall_mem,
             ifde_valid, deex_valid, exmem_valid, memwb_valid, fwd_a_sel, fwd_b_sel};
      total = total + 1;
      if (e.cyc != cyc || act !== e.obs || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
        bad = bad + 1;
        $display("FAIL %s: got stalls/valids/fa/fb=%b sc=%0d fc=%0d, want %b sc=%0d fc=%0d",
                 e.name, act, stall_cnt, flush_cnt, e.obs, e.sc, e.fc);
      end
    end
  end

  task automatic push_exp(input string name, input logic [4:0] st, input logic [3:0] v,
                          input logic [1:0] fa, input logic [1:0] fb, input int sc, input int fc);
    exp_t x;
    x.cyc  = cyc;
    x.name = name;
    x.obs  = {st, v, fa, fb};
    x.sc   = 32'(sc);
    x.fc   = 32'(fc);
    q.push_back(x);
  endtask

  task automatic idle();
    de_rs1 = 5'd0; de_rs2 = 5'd0; de_rs1_used = 1'b0; de_rs2_used = 1'b0;
    ex_rd = 5'd0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    mem_rd = 5'd0; mem_reg_write = 1'b0; mem_access = 1'b0; dmem_ready = 1'b1;
    wb_rd = 5'd0; wb_reg_write = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    idle();
  endtask

  task automatic set_de(input logic [4:0] r1, input logic [4:0] r2);
    de_rs1 = r1; de_rs2 = r2; de_rs1_used = 1'b1; de_rs2_used = 1'b1;
  endtask

  initial begin
    RESET = 1'b1;
    idle();
    @(posedge CLK);
    @(posedge CLK);
    #1;
    push_exp("reset", 5'b00000, 4'b0000, 2'b00, 2'b00, 0, 0);
    RESET = 1'b0;
    tick(); push_exp("release1", 5'b00000, 4'b1000, 2'b00, 2'b00, 0, 0);
    tick(); push_exp("fill2",    5'b00000, 4'b1100, 2'b00, 2'b00, 0, 0);
    tick(); push_exp("fill3",    5'b00000, 4'b1110, 2'b00, 2'b00, 0, 0);
    tick(); push_exp("fill4",    5'b00000, 4'b1111, 2'b00, 2'b00, 0, 0);

`ifdef OTTER_FWD_EN
    // lw x5 in EX, add x6,x5,x1 in DE
    tick(); ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1; set_de(5'd5, 5'd1);
    push_exp("lu_stall", 5'b11100, 4'b1111, 2'b00, 2'b00, 0, 0);
    tick(); ex_rd = 5'd6; ex_reg_write = 1'b1; mem_rd = 5'd5; mem_reg_write = 1'b1; set_de(5'd5, 5'd1);
    push_exp("lu_release", 5'b00000, 4'b1011, 2'b00, 2'b00, 1, 0);
    tick(); push_exp("lu_fwd", 5'b00000, 4'b1101, 2'b10, 2'b00, 1, 0);
    tick(); push_exp("lu_fill3", 5'b00000, 4'b1110, 2'b00, 2'b00, 1, 0);
    tick(); push_exp("lu_fill4", 5'b00000, 4'b1111, 2'b00, 2'b00, 1, 0);
    // add x5 in EX (older x5 writer in MEM), sub x7,x5,x5 in DE
    tick(); ex_rd = 5'd5; ex_reg_write = 1'b1; mem_rd = 5'd5; mem_reg_write = 1'b1; set_de(5'd5, 5'd5);
    push_exp("alu_b2b", 5'b00000, 4'b1111, 2'b00, 2'b00, 1, 0);
    // x0 dest never forwards; rs2 picks the MEM producer
    tick(); ex_rd = 5'd0; ex_reg_write = 1'b1; mem_rd = 5'd7; mem_reg_write = 1'b1; set_de(5'd0, 5'd7);
    push_exp("alu_fwd01", 5'b00000, 4'b1111, 2'b01, 2'b01, 1, 0);
    tick(); push_exp("x0_fwd10", 5'b00000, 4'b1111, 2'b00, 2'b10, 1, 0);
`else
    // add x5 in EX, add x6,x5,x0 in DE; producer walks EX -> MEM -> WB
    tick(); ex_rd = 5'd5; ex_reg_write = 1'b1; set_de(5'd5, 5'd0);
    push_exp("raw_ex", 5'b11100, 4'b1111, 2'b00, 2'b00, 0, 0);
    tick(); ex_rd = 5'd6; ex_reg_write = 1'b1; mem_rd = 5'd5; mem_reg_write = 1'b1; set_de(5'd5, 5'd0);
    push_exp("raw_mem", 5'b11100, 4'b1011, 2'b00, 2'b00, 1, 0);
    tick(); mem_rd = 5'd6; mem_reg_write = 1'b1; wb_rd = 5'd5; wb_reg_write = 1'b1; set_de(5'd5, 5'd0);
    push_exp("raw_wb", 5'b11100, 4'b1001, 2'b00, 2'b00, 2, 0);
    tick(); wb_rd = 5'd6; wb_reg_write = 1'b1; set_de(5'd5, 5'd0);
    push_exp("raw_clear", 5'b00000, 4'b1000, 2'b00, 2'b00, 3, 0);
    tick(); push_exp("raw_fill2", 5'b00000, 4'b1100, 2'b00, 2'b00, 3, 0);
    tick(); push_exp("raw_fill3", 5'b00000, 4'b1110, 2'b00, 2'b00, 3, 0);
    tick(); push_exp("raw_fill4", 5'b00000, 4'b1111, 2'b00, 2'b00, 3, 0);
`endif

    // Branch taken while the DE instruction also has a hazard on the EX load
    tick(); ex_branch_taken = 1'b1; ex_rd = 5'd5; ex_reg_write = 1'b1; ex_mem_read = 1'b1; set_de(5'd5, 5'd0);
    de_rs2_used = 1'b0;
    push_exp("br_nostall", 5'b00000, 4'b1111, 2'b00, 2'b00, BASE, 0);
    tick(); push_exp("br_flushed", 5'b00000, 4'b0011, BR_FA, 2'b00, BASE, 1);
    tick(); push_exp("br_fill1", 5'b00000, 4'b1001, 2'b00, 2'b00, BASE, 1);
    tick(); push_exp("br_fill2", 5'b00000, 4'b1100, 2'b00, 2'b00, BASE, 1);
    tick(); push_exp("br_fill3", 5'b00000, 4'b1110, 2'b00, 2'b00, BASE, 1);
    tick(); push_exp("br_fill4", 5'b00000, 4'b1111, 2'b00, 2'b00, BASE, 1);

    // Load in MEM waits 3 cycles; a branch during the wait is held off until exit
    tick(); mem_access = 1'b1; dmem_ready = 1'b0; ex_branch_taken = 1'b1;
    push_exp("wait1", 5'b11111, 4'b1111, 2'b00, 2'b00, BASE, 1);
    tick(); mem_access = 1'b1; dmem_ready = 1'b0;
    push_exp("wait2", 5'b11111, 4'b1110, 2'b00, 2'b00, BASE + 1, 1);
    tick(); mem_access = 1'b1; dmem_ready = 1'b0;
    push_exp("wait3", 5'b11111, 4'b1110, 2'b00, 2'b00, BASE + 2, 1);
    tick(); mem_access = 1'b1; ex_branch_taken = 1'b1;
    push_exp("wait_exit_br", 5'b00000, 4'b1110, 2'b00, 2'b00, BASE + 3, 1);
    tick(); push_exp("wait_flushed", 5'b00000, 4'b0011, 2'b00, 2'b00, BASE + 3, 2);
    tick(); push_exp("wait_fill1", 5'b00000, 4'b1001, 2'b00, 2'b00, BASE + 3, 2);
    tick(); push_exp("wait_fill2", 5'b00000, 4'b1100, 2'b00, 2'b00, BASE + 3, 2);
    tick(); push_exp("wait_fill3", 5'b00000, 4'b1110, 2'b00, 2'b00, BASE + 3, 2);
    tick(); push_exp("wait_fill4", 5'b00000, 4'b1111, 2'b00, 2'b00, BASE + 3, 2);

    // Reset asserted in the middle of a memory wait
    tick(); mem_access = 1'b1; dmem_ready = 1'b0;
    push_exp("rst_pre", 5'b11111, 4'b1111, 2'b00, 2'b00, BASE + 3, 2);
    tick(); mem_access = 1'b1; dmem_ready = 1'b0; RESET = 1'b1;
    push_exp("rst_gates", 5'b00000, 4'b1110, 2'b00, 2'b00, BASE + 4, 2);
    tick(); RESET = 1'b0;
    push_exp("rst_cleared", 5'b00000, 4'b0000, 2'b00, 2'b00, 0, 0);
    tick(); push_exp("rst_release", 5'b00000, 4'b1000, 2'b00, 2'b00, 0, 0);

    repeat (3) @(negedge CLK);
    if (q.size() > 0) begin
      $display("FAIL drain: got %0d unchecked expectations, want 0", q.size());
      total = total + 1;
      bad   = bad + 1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
